// File: rtl/scarv_soc_bram_bridge_pkg.sv
// Shared definitions for the SoC BRAM bridge: response entry layout, default size, FIFO depth.
`ifndef SCARV_SOC_BRAM_RSP_FIFO_DEPTH
`define SCARV_SOC_BRAM_RSP_FIFO_DEPTH 2
`endif

package scarv_soc_bram_bridge_pkg;

  localparam int unsigned RSP_W          = 33;
  localparam int unsigned DEFAULT_DEPTH  = 1024;
  localparam int unsigned RSP_FIFO_DEPTH = `SCARV_SOC_BRAM_RSP_FIFO_DEPTH;
  localparam int unsigned RSP_CNT_W      = $clog2(RSP_FIFO_DEPTH + 1);

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  function automatic logic [RSP_CNT_W-1:0] occupancy(input logic s1_valid,
                                                     input logic [RSP_CNT_W-1:0] fifo_count);
    return fifo_count + {{(RSP_CNT_W-1){1'b0}}, s1_valid};
  endfunction

endpackage

// File: rtl/scarv_soc_bram_bridge_rsp_fifo.sv
// Small synchronous response FIFO; same-cycle push and pop allowed, pointers wrap naturally.
module scarv_soc_bram_bridge_rsp_fifo
  import scarv_soc_bram_bridge_pkg::*;
#(
  parameter int unsigned WIDTH = RSP_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_push,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_pop,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [RSP_CNT_W-1:0] o_count
);

  localparam int unsigned PTR_W = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;

  logic [WIDTH-1:0]     r_mem [RSP_FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [RSP_CNT_W-1:0] r_count;
  logic                 w_push;
  logic                 w_pop;

  assign o_full  = (r_count == RSP_CNT_W'(RSP_FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_push = i_push && (!o_full || i_pop);
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < RSP_FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/scarv_soc_bram_bridge.sv
// req/gnt + recv/ack bus to BRAM port A adapter with 1-cycle read latency absorption.
// Optional: SCARV_SOC_BRAM_BRIDGE_ALIGN_CHECK_EN adds misaligned / zero-strobe write errors.
module scarv_soc_bram_bridge
  import scarv_soc_bram_bridge_pkg::*;
#(
  parameter  int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter  int unsigned WRITE_EN = 1,
  localparam int unsigned LW       = $clog2(DEPTH)
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  input  logic          mem_req,
  output logic          mem_gnt,
  input  logic          mem_wen,
  input  logic [3:0]    mem_strb,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   mem_wdata,
  output logic          mem_recv,
  input  logic          mem_ack,
  output logic          mem_error,
  output logic [31:0]   mem_rdata,
  output logic          bram_en,
  output logic [3:0]    bram_wen,
  output logic [LW-1:0] bram_addr,
  output logic [31:0]   bram_wdata,
  input  logic [31:0]   bram_rdata
);

  logic                 r_s1_valid;
  logic                 r_s1_err;
  logic                 r_s1_wr;

  logic                 w_range_err;
  logic                 w_wr_err;
  logic                 w_align_err;
  logic                 w_err;
  logic                 w_hs;
  logic [RSP_CNT_W-1:0] w_occ;
  rsp_t                 w_s1_rsp;
  rsp_t                 w_head;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [RSP_CNT_W-1:0] w_fifo_count;
  logic                 w_push;
  logic                 w_pop;

  assign w_range_err = (mem_addr >= 32'(DEPTH));
  assign w_wr_err    = mem_wen && (WRITE_EN == 0);
`ifdef SCARV_SOC_BRAM_BRIDGE_ALIGN_CHECK_EN
  assign w_align_err = (mem_addr[1:0] != 2'b00) || (mem_wen && (mem_strb == 4'b0000));
`else
  assign w_align_err = 1'b0;
`endif
  assign w_err = w_range_err || w_wr_err || w_align_err;

  // Grant depends only on registered occupancy, never on mem_req or mem_ack.
  assign w_occ   = occupancy(r_s1_valid, w_fifo_count);
  assign mem_gnt = (w_occ < RSP_CNT_W'(2)) && g_resetn;
  assign w_hs    = mem_req && mem_gnt;

  assign bram_en    = w_hs && !w_err;
  assign bram_wen   = (bram_en && mem_wen) ? mem_strb : '0;
  assign bram_addr  = mem_addr[LW-1:0];
  assign bram_wdata = mem_wdata;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_wr    <= 1'b0;
    end else begin
      r_s1_valid <= w_hs;
      if (w_hs) begin
        r_s1_err <= w_err;
        r_s1_wr  <= mem_wen;
      end
    end
  end

  assign w_s1_rsp.err  = r_s1_err;
  assign w_s1_rsp.data = (r_s1_err || r_s1_wr) ? '0 : bram_rdata;

  // The stage result bypasses the FIFO only when nothing older is queued.
  assign w_pop  = !w_fifo_empty && mem_ack;
  assign w_push = r_s1_valid && !(w_fifo_empty && mem_ack) && (!w_fifo_full || w_pop);

  scarv_soc_bram_bridge_rsp_fifo #(
    .WIDTH (RSP_W)
  ) u_rsp_fifo (
    .i_clk   (g_clk),
    .i_rst_n (g_resetn),
    .i_push  (w_push),
    .i_data  (w_s1_rsp),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_comb begin
    mem_recv  = 1'b0;
    mem_error = 1'b0;
    mem_rdata = '0;
    if (!w_fifo_empty) begin
      mem_recv  = 1'b1;
      mem_error = w_head.err;
      mem_rdata = w_head.data;
    end else if (r_s1_valid) begin
      mem_recv  = 1'b1;
      mem_error = w_s1_rsp.err;
      mem_rdata = w_s1_rsp.data;
    end
  end

endmodule

// File: tb/tb_scarv_soc_bram_bridge.sv
// Bench for scarv_soc_bram_bridge: in-order response model plus directed literal checks.
module tb_scarv_soc_bram_bridge;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        mem_req, mem_wen, mem_ack;
  logic [3:0]  mem_strb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_recv, mem_error;
  logic [31:0] mem_rdata;
  logic        bram_en;
  logic [3:0]  bram_wen;
  logic [9:0]  bram_addr;
  logic [31:0] bram_wdata, bram_rdata;

  logic        rom_req;
  logic        rom_gnt, rom_recv, rom_error;
  logic [31:0] rom_rdata;
  logic        rom_bram_en;
  logic [3:0]  rom_bram_wen;
  logic [9:0]  rom_bram_addr;
  logic [31:0] rom_bram_wdata, rom_bram_rdata;

  logic        r_preload;
  logic [31:0] bmem   [256];
  logic [31:0] rmem   [256];
  logic [31:0] shadow [256];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          err;
    logic [31:0] data;
  } exp_rsp_t;
  exp_rsp_t q[$];

  always #5 g_clk = ~g_clk;

  scarv_soc_bram_bridge #(.DEPTH(1024), .WRITE_EN(1)) u_dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_recv(mem_recv), .mem_ack(mem_ack),
    .mem_error(mem_error), .mem_rdata(mem_rdata),
    .bram_en(bram_en), .bram_wen(bram_wen), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  scarv_soc_bram_bridge #(.DEPTH(1024), .WRITE_EN(0)) u_rom (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .mem_req(rom_req), .mem_gnt(rom_gnt), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_recv(rom_recv), .mem_ack(1'b1),
    .mem_error(rom_error), .mem_rdata(rom_rdata),
    .bram_en(rom_bram_en), .bram_wen(rom_bram_wen), .bram_addr(rom_bram_addr),
    .bram_wdata(rom_bram_wdata), .bram_rdata(rom_bram_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : 32'h11223344 + 32'(i);
  endfunction

  // Behavioural BRAMs: one-cycle registered read.
  always @(posedge g_clk) begin
    if (r_preload) begin
      for (int i = 0; i < 256; i++) bmem[i] <= init_word(i);
    end else if (bram_en) begin
      for (int b = 0; b < 4; b++)
        if (bram_wen[b]) bmem[bram_addr[9:2]][8*b +: 8] <= bram_wdata[8*b +: 8];
      bram_rdata <= bmem[bram_addr[9:2]];
    end
  end

  always @(posedge g_clk) begin
    if (r_preload) begin
      for (int i = 0; i < 256; i++) rmem[i] <= init_word(i);
    end else if (rom_bram_en) begin
      for (int b = 0; b < 4; b++)
        if (rom_bram_wen[b]) rmem[rom_bram_addr[9:2]][8*b +: 8] <= rom_bram_wdata[8*b +: 8];
      rom_bram_rdata <= rmem[rom_bram_addr[9:2]];
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @%0t: actual=%h required=%h", nm, $time, act, req);
    end
  endtask

  // Model: every granted request owes one response, delivered in grant order starting the next cycle.
  always @(negedge g_clk) begin
    bit          m_gnt, m_hs, m_err, m_en;
    logic [31:0] d;
    int          w;
    if (r_preload) for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    if (!g_resetn) begin
      q.delete();
      cmp("rst_gnt", 32'(mem_gnt), 0);
      cmp("rst_recv", 32'(mem_recv), 0);
      cmp("rst_error", 32'(mem_error), 0);
      cmp("rst_rdata", mem_rdata, 0);
      cmp("rst_bram_en", 32'(bram_en), 0);
      cmp("rst_bram_wen", 32'(bram_wen), 0);
    end else begin
      m_gnt = (q.size() < 2);
      cmp("gnt", 32'(mem_gnt), 32'(m_gnt));
      cmp("recv", 32'(mem_recv), 32'(q.size() > 0));
      cmp("error", 32'(mem_error), (q.size() > 0) ? 32'(q[0].err) : 0);
      cmp("rdata", mem_rdata, (q.size() > 0) ? q[0].data : 0);
      m_hs  = mem_req && m_gnt;
      m_err = (mem_addr >= 32'd1024);
`ifdef SCARV_SOC_BRAM_BRIDGE_ALIGN_CHECK_EN
      m_err = m_err || (mem_addr[1:0] != 2'b00) || (mem_wen && mem_strb == 4'b0000);
`endif
      m_en = m_hs && !m_err;
      cmp("bram_en", 32'(bram_en), 32'(m_en));
      cmp("bram_wen", 32'(bram_wen), (m_en && mem_wen) ? 32'(mem_strb) : 0);
      if (m_en) begin
        cmp("bram_addr", 32'(bram_addr), mem_addr % 1024);
        cmp("bram_wdata", bram_wdata, mem_wdata);
      end
      if (q.size() > 0 && mem_ack) void'(q.pop_front());
      if (m_hs) begin
        w = int'(mem_addr[9:2]);
        d = (m_err || mem_wen) ? 32'h0 : shadow[w];
        if (m_en && mem_wen)
          for (int b = 0; b < 4; b++)
            if (mem_strb[b]) shadow[w][8*b +: 8] = mem_wdata[8*b +: 8];
        q.push_back('{err: m_err, data: d});
      end
    end
  end

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic peek();
    #3;
  endtask

  task automatic drive(input logic wen, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdata);
    mem_req   = 1'b1;
    mem_wen   = wen;
    mem_addr  = addr;
    mem_strb  = strb;
    mem_wdata = wdata;
  endtask

  task automatic idle();
    mem_req = 1'b0;
    mem_wen = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_g, n_r;
    g_resetn = 1'b0; r_preload = 1'b1; rom_req = 1'b0; mem_ack = 1'b1;
    mem_req = 1'b0; mem_wen = 1'b0; mem_strb = '0; mem_addr = '0; mem_wdata = '0;
    step(); step();
    peek();
    cmp("reset_gnt", 32'(mem_gnt), 0);
    cmp("reset_recv", 32'(mem_recv), 0);
    step();
    r_preload = 1'b0; g_resetn = 1'b1;
    peek();
    cmp("post_reset_gnt", 32'(mem_gnt), 1);

    // Plain read, ack high
    step(); drive(0, 32'h10, 4'h0, 0); peek();
    cmp("rd10_gnt", 32'(mem_gnt), 1);
    step(); idle(); peek();
    cmp("rd10_recv", 32'(mem_recv), 1);
    cmp("rd10_rdata", mem_rdata, 32'hDEADBEEF);
    cmp("rd10_err", 32'(mem_error), 0);

    // Byte write then read back
    step(); drive(1, 32'h20, 4'b0100, 32'h00AB0000); peek();
    cmp("wr20_bram_wen", 32'(bram_wen), 32'h4);
    step(); idle(); peek();
    cmp("wr20_recv", 32'(mem_recv), 1);
    cmp("wr20_rdata", mem_rdata, 0);
    step(); drive(0, 32'h20, 4'h0, 0);
    step(); idle(); peek();
    cmp("rd20_rdata", mem_rdata, 32'h11AB334C);

    // Back-pressure
    step(); mem_ack = 1'b0; drive(0, 32'h40, 4'h0, 0); peek();
    cmp("bp_gnt0", 32'(mem_gnt), 1);
    step(); drive(0, 32'h44, 4'h0, 0); peek();
    cmp("bp_gnt1", 32'(mem_gnt), 1);
    cmp("bp_head0", mem_rdata, 32'h11223354);
    step(); drive(0, 32'h48, 4'h0, 0); peek();
    cmp("bp_gnt2_blocked", 32'(mem_gnt), 0);
    step(); mem_ack = 1'b1; peek();
    cmp("bp_gnt2_still_blocked", 32'(mem_gnt), 0);
    cmp("bp_head_stable", mem_rdata, 32'h11223354);
    step(); peek();
    cmp("bp_gnt2_late", 32'(mem_gnt), 1);
    cmp("bp_head1", mem_rdata, 32'h11223355);
    step(); idle(); peek();
    cmp("bp_head2", mem_rdata, 32'h11223356);

    // Out of range, zero-strobe write
    step(); drive(0, 32'h400, 4'h0, 0); peek();
    cmp("oor_gnt", 32'(mem_gnt), 1);
    cmp("oor_bram_en", 32'(bram_en), 0);
    step(); idle(); peek();
    cmp("oor_err", 32'(mem_error), 1);
    cmp("oor_rdata", mem_rdata, 0);
    step(); drive(1, 32'h24, 4'h0, 32'hFFFFFFFF);
    step(); idle(); peek();
`ifdef SCARV_SOC_BRAM_BRIDGE_ALIGN_CHECK_EN
    cmp("zstrb_err", 32'(mem_error), 1);
`else
    cmp("zstrb_err", 32'(mem_error), 0);
`endif

    // ROM instance rejects writes
    step(); rom_req = 1'b1; mem_wen = 1'b1; mem_addr = 0; mem_strb = 4'hF;
    mem_wdata = 32'hCAFEF00D; peek();
    cmp("rom_wr_gnt", 32'(rom_gnt), 1);
    cmp("rom_wr_bram_en", 32'(rom_bram_en), 0);
    step(); rom_req = 1'b0; mem_wen = 1'b0; peek();
    cmp("rom_wr_recv", 32'(rom_recv), 1);
    cmp("rom_wr_err", 32'(rom_error), 1);
    cmp("rom_wr_rdata", rom_rdata, 0);
    step(); rom_req = 1'b1; mem_addr = 0;
    step(); rom_req = 1'b0; peek();
    cmp("rom_rd_err", 32'(rom_error), 0);
    cmp("rom_rd_rdata", rom_rdata, 32'h11223344);

    // Streaming 16 reads
    n_g = 0; n_r = 0;
    for (int k = 0; k <= 16; k++) begin
      step();
      if (k < 16) drive(0, 32'h80 + 32'(4 * k), 4'h0, 0); else idle();
      peek();
      if (k < 16 && mem_gnt) n_g++;
      if (k >= 1) begin
        if (mem_recv) n_r++;
        cmp("stream_rdata", mem_rdata, 32'h11223344 + 32'(32 + k - 1));
      end
    end
    cmp("stream_gnts", n_g, 16);
    cmp("stream_recvs", n_r, 16);

    // Misaligned read
    step(); drive(0, 32'h13, 4'h0, 0);
    step(); idle(); peek();
`ifdef SCARV_SOC_BRAM_BRIDGE_ALIGN_CHECK_EN
    cmp("mis13_err", 32'(mem_error), 1);
    cmp("mis13_rdata", mem_rdata, 0);
`else
    cmp("mis13_err", 32'(mem_error), 0);
    cmp("mis13_rdata", mem_rdata, 32'hDEADBEEF);
`endif

    // Reset mid-transaction
    step(); drive(0, 32'h10, 4'h0, 0); peek();
    cmp("rst_mid_gnt", 32'(mem_gnt), 1);
    step(); g_resetn = 1'b0; idle(); peek();
    cmp("rst_mid_recv", 32'(mem_recv), 0);
    cmp("rst_mid_gnt_low", 32'(mem_gnt), 0);
    step(); step(); g_resetn = 1'b1; peek();
    cmp("rst_rel_gnt", 32'(mem_gnt), 1);
    cmp("rst_rel_recv", 32'(mem_recv), 0);
    step(); peek();
    cmp("rst_rel_no_stale", 32'(mem_recv), 0);

    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scarv_soc_bram_bridge.md
Name: scarv_soc_bram_bridge

Overview:
- Bus-to-BRAM adapter that sits directly upstream of the SoC dual-port BRAM and drives its port A.
- Converts the CPU/interconnect req/gnt + recv/ack memory handshake into BRAM enable/byte-write/address/data strobes.
- Absorbs the BRAM's fixed 1-cycle read latency; buffers responses under back-pressure; flags out-of-range and illegal-write accesses.

Parameters:
- DEPTH, 1024, BRAM size in bytes (power of two); LW = clog2(DEPTH) derived locally.
- WRITE_EN, 1, 0 = ROM: any write is answered with error and never reaches the BRAM.

Ports:
- g_clk  in  1  single clock.
- g_resetn  in  1  reset, asynchronous, active-low.
- mem_req  in  1  request valid.
- mem_gnt  out  1  request accepted this cycle when mem_req && mem_gnt.
- mem_wen  in  1  1 = write, 0 = read.
- mem_strb  in  4  byte write strobes.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data.
- mem_recv  out  1  response valid.
- mem_ack  in  1  response consumed when mem_recv && mem_ack.
- mem_error  out  1  response error flag.
- mem_rdata  out  32  read data.
- bram_en  out  1  to BRAM ena.
- bram_wen  out  4  to BRAM wea.
- bram_addr  out  LW  to BRAM addra (byte address, word-indexed internally).
- bram_wdata  out  32  to BRAM dina.
- bram_rdata  in  32  from BRAM douta, valid the cycle after bram_en.

Behaviour:
- Reset (async, g_resetn=0): stage and FIFO state cleared. While g_resetn=0: mem_gnt=0, mem_recv=0, mem_error=0, mem_rdata=0, bram_en=0, bram_wen=0. An in-flight transaction is discarded and no response is ever produced for it.
- Error at issue: err = (mem_addr >= DEPTH) || (mem_wen && !WRITE_EN).
- Issue (combinational from request):
  - bram_en = mem_req && mem_gnt && !err.
  - bram_wen = mem_wen ? mem_strb : 0, gated by bram_en.
  - bram_addr = mem_addr[LW-1:0]; bram_wdata = mem_wdata.
- Stage register s1 {valid, err, wr} loads on every handshake. s1.valid clears when no handshake occurs.
- Response FIFO: 2 entries of {err, data}. Pushed with s1's result when s1.valid and the response is not consumed the same cycle.
  - data = (err || wr) ? 0 : bram_rdata; write responses always return rdata=0.
- Response port:
  - FIFO non-empty: head drives mem_recv/mem_error/mem_rdata.
  - FIFO empty and s1.valid: s1 result is bypassed, so latency is exactly 1 cycle from grant to mem_recv.
  - Otherwise mem_recv=0, mem_rdata=0, mem_error=0.
- Ordering: responses are strictly in grant order. The head pops on mem_recv && mem_ack.
- Flow control: occ = s1.valid + fifo_count; mem_gnt = (occ < 2) && g_resetn.
  - mem_gnt has no combinational dependence on mem_ack or mem_req.
  - Full throughput (1 txn/cycle) when mem_ack is held high.
- Simultaneous push (from s1) and pop (head acked) in the same cycle: count unchanged. FIFO pointers wrap modulo 2.
- mem_recv stays asserted with stable mem_error/mem_rdata until acked.

Optional Feature:
- Macro: SCARV_SOC_BRAM_BRIDGE_ALIGN_CHECK_EN.
- Defined: err additionally includes (mem_addr[1:0] != 0) and, for writes, (mem_strb == 0). Such accesses get an error response with no BRAM access.
- Undefined: mem_addr[1:0] is passed through and ignored by the BRAM; zero-strobe writes complete normally.

Decomposition:
- Shared header scarv_soc_bram_defs holds:
  - the response entry width constant (33 = err + data);
  - the default DEPTH;
  - a localparam-style macro for the FIFO depth (2).
- One sub-module, scarv_soc_bram_bridge_rsp_fifo: 2-entry synchronous FIFO with push/pop/full/empty/count, async active-low reset, and same-cycle push+pop allowed.

Test Plan:
- Read with ack tied high: preload word 0x10 = 0xDEADBEEF; req read addr 0x10 -> mem_gnt=1 that cycle, next cycle mem_recv=1, mem_rdata=0xDEADBEEF, mem_error=0.
- Byte write then read: write addr 0x20, strb=4'b0100, wdata=0x00AB0000 -> bram_wen=4'b0100 and write response rdata=0; read 0x20 returns byte2=0xAB with other bytes unchanged.
- Back-pressure: mem_ack=0, issue 3 reads -> first two granted, mem_gnt=0 on the third. Raise ack -> responses return in order, then the third is granted.
- Out of range / ROM: DEPTH=1024, read 0x400 -> bram_en=0, mem_error=1, rdata=0. With WRITE_EN=0, a write to 0x0 -> error=1 and BRAM contents unchanged.
- Streaming: 16 back-to-back reads with ack=1 -> 16 consecutive recv cycles, no bubbles, correct order. Macro-on variant: read 0x13 -> error=1.
- Reset mid-operation: grant a read, assert g_resetn=0 the next cycle -> mem_recv=0 immediately. After release, mem_gnt=1, no stale response, occ=0.
